// File: rtl/tt_um_serial_adder8_if.sv
// Pin bundle of the serial adder: operand/control inputs and result/status outputs.
interface tt_um_serial_adder8_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/tt_um_serial_adder8.sv
// Bit-serial 8-bit adder: one operand bit per enabled clock, result after 8 cycles.
// Optional subtract mode is compiled in only when SERIAL_ADDER_SUB_EN is defined.
module tt_um_serial_adder8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  tt_um_serial_adder8_if core_bus ();

  assign core_bus.ena    = ena;
  assign core_bus.ui_in  = ui_in;
  assign core_bus.uio_in = uio_in;
  assign uo_out          = core_bus.uo_out;
  assign uio_out         = core_bus.uio_out;
  assign uio_oe          = core_bus.uio_oe;

  tt_um_serial_adder8_core u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (core_bus.slave)
  );
endmodule

module tt_um_serial_adder8_core (
  input  logic                  clk,
  input  logic                  rst_n,
  tt_um_serial_adder8_if.slave  bus
);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    maj3 = (x & y) | (x & z) | (y & z);
  endfunction

  state_e     state_q;
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic [7:0] work_q;
  logic [7:0] res_q;
  logic       carry_q;
  logic       cout_q;
  logic       sub_q;
  logic       busy_q;
  logic       done_q;
  logic [2:0] cnt_q;

  logic       start_s;
  logic       load_a_s;
  logic       load_b_s;
  logic       cin_s;
  logic       sub_s;
  logic       carry_init_s;
  logic       unused_s;

  assign start_s  = bus.uio_in[0];
  assign load_a_s = bus.uio_in[1];
  assign load_b_s = bus.uio_in[2];
  assign cin_s    = bus.uio_in[3];

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_s    = bus.uio_in[4];
  assign unused_s = ^{1'b0, bus.uio_in[7:5]};
`else
  assign sub_s    = 1'b0;
  assign unused_s = ^{1'b0, bus.uio_in[7:4]};
`endif

  // Subtraction is A + ~B + 1, so the incoming carry is forced high.
  assign carry_init_s = sub_s ? 1'b1 : cin_s;

  logic       b_bit_s;
  logic       sum_bit_d;
  logic       carry_d;
  logic [7:0] work_d;

  // One full-adder step on the current LSBs.
  always_comb begin
    b_bit_s   = b_q[0] ^ sub_q;
    sum_bit_d = a_q[0] ^ b_bit_s ^ carry_q;
    carry_d   = maj3(a_q[0], b_bit_s, carry_q);
    work_d    = {sum_bit_d, work_q[7:1]};
  end

  // Controller and datapath: operand loads, 8-step shift-add, result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      work_q  <= 8'h00;
      res_q   <= 8'h00;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      sub_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= 3'd0;
    end else if (bus.ena) begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          // A load in the same cycle as start takes priority and suppresses it.
          if (load_a_s || load_b_s) begin
            if (load_a_s) begin
              a_q <= bus.ui_in;
            end
            if (load_b_s) begin
              b_q <= bus.ui_in;
            end
          end else if (start_s) begin
            state_q <= ST_RUN;
            cnt_q   <= 3'd0;
            work_q  <= 8'h00;
            carry_q <= carry_init_s;
            sub_q   <= sub_s;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          a_q     <= {1'b0, a_q[7:1]};
          b_q     <= {1'b0, b_q[7:1]};
          work_q  <= work_d;
          carry_q <= carry_d;
          cnt_q   <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            res_q   <= work_d;
            cout_q  <= carry_d;
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.uo_out  = res_q;
  assign bus.uio_out = {cout_q, busy_q, done_q, 5'b00000};
  assign bus.uio_oe  = 8'hE0;
endmodule
